// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes and
// datapath mux/ALU select codes.
package control_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9
   } estado_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   localparam logic [1:0] ALUB_REGB   = 2'b00;
   localparam logic [1:0] ALUB_CUATRO = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_X4 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SALTO  = 2'b10;

   // States that wait on the memory ready handshake
   function automatic logic esEstadoMem(input estado_t e);
      return (e == FETCH) || (e == MEM_READ) || (e == MEM_WRITE);
   endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory wait counter: counts stalled cycles and flags when the limit is reached.
module contador_espera #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expira
);

   localparam logic [7:0] LIMITE = TIMEOUT[7:0];

   logic [7:0] cuenta;

   // Wait-cycle counter; clear has priority over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cuenta <= 8'd0;
      end else if (clr) begin
         cuenta <= 8'd0;
      end else if (inc) begin
         cuenta <= cuenta + 8'd1;
      end else begin
         cuenta <= cuenta;
      end
   end

   assign expira = (cuenta == LIMITE);

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable from the current state.
module control_multiciclo
   import control_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] instru,
   input  logic       mem_listo,
   output logic       EscrPC,
   output logic       EscrPCCond,
   output logic       IoD,
   output logic       LeerMem,
   output logic       EscrMem,
   output logic       EscrIR,
   output logic       MemaReg,
   output logic       RegDest,
   output logic       EscrReg,
   output logic       FuenteALUA,
   output logic [1:0] FuenteALUB,
   output logic [1:0] ALUOp,
   output logic [1:0] FuentePC,
   output logic [3:0] estado,
   output logic       opinvalido,
   output logic       error_mem
);

   estado_t estadoActual;
   estado_t estadoSig;
   logic    esperaMem;
   logic    expira;
   logic    abortoMem;
   logic    opInvalidoDec;
   logic    clrCuenta;
   logic    incCuenta;

   assign esperaMem = esEstadoMem(estadoActual);
   assign abortoMem = esperaMem && !mem_listo && expira;
   // Any state change (including a timeout re-fetch) restarts the wait count
   assign clrCuenta = (estadoSig != estadoActual) || abortoMem;
   assign incCuenta = esperaMem && !mem_listo;

   contador_espera #(.TIMEOUT(TIMEOUT)) uEspera (
      .clk    (clk),
      .rst    (rst),
      .clr    (clrCuenta),
      .inc    (incCuenta),
      .expira (expira)
   );

   // Next-state selection; opcode is only looked at in DECODE and MEM_ADDR
   always_comb begin
      estadoSig     = FETCH;
      opInvalidoDec = 1'b0;
      case (estadoActual)
         FETCH:     estadoSig = mem_listo ? DECODE : FETCH;
         DECODE: begin
            case (instru)
               OP_LW, OP_SW: estadoSig = MEM_ADDR;
               OP_R:         estadoSig = R_EXEC;
               OP_BEQ:       estadoSig = BRANCH;
               OP_J:         estadoSig = JUMP;
               default: begin
                  estadoSig     = FETCH;
                  opInvalidoDec = 1'b1;
               end
            endcase
         end
         MEM_ADDR:  estadoSig = (instru == OP_LW) ? MEM_READ : MEM_WRITE;
         MEM_READ: begin
            if (mem_listo) begin
               estadoSig = MEM_WB;
            end else if (abortoMem) begin
               estadoSig = FETCH;
            end else begin
               estadoSig = MEM_READ;
            end
         end
         MEM_WRITE: estadoSig = (mem_listo || abortoMem) ? FETCH : MEM_WRITE;
         R_EXEC:    estadoSig = R_WB;
         MEM_WB, R_WB, BRANCH, JUMP: estadoSig = FETCH;
         default:   estadoSig = FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estadoActual <= FETCH;
      end else begin
         estadoActual <= estadoSig;
      end
   end

   // Output decode from the registered state; everything held low during reset
   always_comb begin
      EscrPC     = 1'b0;
      EscrPCCond = 1'b0;
      IoD        = 1'b0;
      LeerMem    = 1'b0;
      EscrMem    = 1'b0;
      EscrIR     = 1'b0;
      MemaReg    = 1'b0;
      RegDest    = 1'b0;
      EscrReg    = 1'b0;
      FuenteALUA = 1'b0;
      FuenteALUB = ALUB_REGB;
      ALUOp      = ALUOP_ADD;
      FuentePC   = PC_ALU;
      opinvalido = 1'b0;
      error_mem  = 1'b0;
      if (rst) begin
         EscrPC = 1'b0;
      end else begin
         opinvalido = opInvalidoDec;
         error_mem  = abortoMem;
         case (estadoActual)
            FETCH: begin
               LeerMem    = 1'b1;
               FuenteALUB = ALUB_CUATRO;
               EscrIR     = mem_listo;
               EscrPC     = mem_listo;
            end
            DECODE:    FuenteALUB = ALUB_IMM_X4;
            MEM_ADDR: begin
               FuenteALUA = 1'b1;
               FuenteALUB = ALUB_IMM;
            end
            MEM_READ: begin
               LeerMem = 1'b1;
               IoD     = 1'b1;
            end
            MEM_WB: begin
               EscrReg = 1'b1;
               MemaReg = 1'b1;
            end
            MEM_WRITE: begin
               EscrMem = 1'b1;
               IoD     = 1'b1;
            end
            R_EXEC: begin
               FuenteALUA = 1'b1;
               ALUOp      = ALUOP_FUNCT;
            end
            R_WB: begin
               EscrReg = 1'b1;
               RegDest = 1'b1;
            end
            BRANCH: begin
               FuenteALUA = 1'b1;
               ALUOp      = ALUOP_SUB;
               EscrPCCond = 1'b1;
               FuentePC   = PC_ALUOUT;
            end
            JUMP: begin
               EscrPC   = 1'b1;
               FuentePC = PC_SALTO;
            end
            default: EscrPC = 1'b0;
         endcase
      end
   end

   assign estado = estadoActual;

endmodule
